win_scanner: RTL

Parametrised, sequential successor to the combinational 3×3 win detector. Scans an N×N board held as two occupancy vectors (player A, player B) for any K-in-a-row along rows, columns and both diagonals. It checks one candidate window per clock and reports the first hit together with its window index. It sits between the board registers and the game-control FSM and uses a start/done handshake, so large boards do not need a wide combinational tree.

---
 rtl/win_scanner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/win_scanner.sv
// win_scanner: sequential K-in-a-row detector for an N x N board.
// Walks one candidate window per clock (rows, columns, down diagonals,
// up diagonals) and stops at the first window fully owned by A or B.
// Optional feature macro: WIN_SCAN_DRAW_EN (full-board draw on a no-hit scan).
module win_scanner #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int L  = N - K + 1,
  localparam int W  = 2 * N * L + 2 * L * L,
  localparam int IW = ($clog2(W) < 1) ? 1 : $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N*N-1:0] ain,
  input  logic [N*N-1:0] bin,
  output logic          busy,
  output logic          done,
  output logic          win_a,
  output logic          win_b,
  output logic [IW-1:0] win_idx,
  output logic          draw
);

  localparam int NN = N * N;
  localparam int WP = 1 << IW;
  localparam logic [NN-1:0] ONE = NN'(1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  // Cell mask of window j; indices past W-1 are never visited and stay empty.
  function automatic logic [NN-1:0] win_mask(input int j);
    logic [NN-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int s = 0; s < L; s++)
        if (r * L + s == j)
          for (int i = 0; i < K; i++) m = m | (ONE << (NN - 1 - (r * N + s + i)));
    for (int c = 0; c < N; c++)
      for (int s = 0; s < L; s++)
        if (N * L + c * L + s == j)
          for (int i = 0; i < K; i++) m = m | (ONE << (NN - 1 - ((s + i) * N + c)));
    for (int r = 0; r < L; r++)
      for (int c = 0; c < L; c++)
        if (2 * N * L + r * L + c == j)
          for (int i = 0; i < K; i++) m = m | (ONE << (NN - 1 - ((r + i) * N + c + i)));
    for (int r = K - 1; r < N; r++)
      for (int c = 0; c < L; c++)
        if (2 * N * L + L * L + (r - K + 1) * L + c == j)
          for (int i = 0; i < K; i++) m = m | (ONE << (NN - 1 - ((r - i) * N + c + i)));
    return m;
  endfunction

  // Constant window table, padded to a power of two so idx never indexes past it.
  logic [NN-1:0] masks [WP];
  for (genvar j = 0; j < WP; j++) begin : g_mask
    assign masks[j] = win_mask(j);
  end

  state_t        state_q, state_d;
  logic [NN-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          win_a_q, win_a_d, win_b_q, win_b_d;
  logic [IW-1:0] win_idx_q, win_idx_d;
  logic          draw_q, draw_d;

  logic [NN-1:0] cur_mask;
  logic          hit_a, hit_b, last_win, full_board;

  // Test the current window against the latched board.
  always_comb begin
    cur_mask = masks[idx_q];
    hit_a    = ((a_q & cur_mask) == cur_mask);
    hit_b    = ((b_q & cur_mask) == cur_mask);
    last_win = (idx_q == IW'(W - 1));
  end

`ifdef WIN_SCAN_DRAW_EN
  assign full_board = &(a_q | b_q);
`else
  assign full_board = 1'b0;
`endif

  // Next-state: accept in IDLE/DONE, one window per cycle in SCAN.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    win_a_d   = win_a_q;
    win_b_d   = win_b_q;
    win_idx_d = win_idx_q;
    draw_d    = draw_q;
    case (state_q)
      S_SCAN: begin
        if (hit_a || hit_b) begin
          win_a_d   = hit_a;
          win_b_d   = hit_b;
          win_idx_d = idx_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (last_win) begin
          draw_d    = full_board;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          idx_d     = idx_q + IW'(1);
        end
      end
      default: begin
        if (start) begin
          a_d       = ain;
          b_d       = bin;
          win_a_d   = 1'b0;
          win_b_d   = 1'b0;
          win_idx_d = '0;
          draw_d    = 1'b0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_SCAN;
        end else begin
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // State and result registers; reset discards any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_a_q   <= 1'b0;
      win_b_q   <= 1'b0;
      win_idx_q <= '0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      win_a_q   <= win_a_d;
      win_b_q   <= win_b_d;
      win_idx_q <= win_idx_d;
      draw_q    <= draw_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign win_a   = win_a_q;
  assign win_b   = win_b_q;
  assign win_idx = win_idx_q;
  assign draw    = draw_q;

endmodule
